// File: rtl/par2ser_pkg.sv
// Shared constants for the serial-link blocks: FSM encodings, default word width,
// and the bit-counter width helper.
package par2ser_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter must hold WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/par2ser_if.sv
// Parallel load handshake plus serial output bundle between a word producer and par2ser.
// No latency of its own; ready is the only backpressure signal carried here.
interface par2ser_if #(
    parameter int WIDTH = par2ser_pkg::WIDTH_DEFAULT
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (output din, load, input  ready, sout, busy, done);
    modport slave  (input  din, load, output ready, sout, busy, done);
endinterface

// File: rtl/par2ser.sv
// Parallel-to-serial shifter: first bit one cycle after the accepting edge, WIDTH bits/word.
// Backpressure: ready low while shifting except on the last bit; load ignored when not ready.
module par2ser
    import par2ser_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    par2ser_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        if (bus.load && ready) begin
            // Covers both a fresh start from IDLE and a gap-free reload on the last bit.
            state_d = SHIFT;
            sreg_d  = bus.din;
            cnt_d   = CNT_LAST;
        end else if (state_q == SHIFT) begin
            if (cnt_q != '0) begin
                cnt_d  = cnt_q - 1'b1;
                sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, sreg_q[WIDTH-1:1]};
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Outputs depend only on registered state so load never reaches ready combinationally.
    always_comb begin
        ready    = (state_q == IDLE) || (cnt_q == '0);
        bus.busy = (state_q == SHIFT);
        bus.done = (state_q == SHIFT) && (cnt_q == '0);
        bus.sout = 1'b0;
        if (state_q == SHIFT) begin
            bus.sout = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        end
        bus.ready = ready;
    end

endmodule
